// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared definitions for the fetch buffer: jump request
//               encodings, the default reset PC and the pointer-width helper
//               used to size the instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Jump request encodings carried on j_taken. J_RSVD is accepted on the
    // port but never redirects the front end.
    typedef enum logic [1:0] {
        J_NONE = 2'd0,
        J_IMM  = 2'd1,
        J_REG  = 2'd2,
        J_RSVD = 2'd3
    } jump_kind_e;

    // PC value after reset unless overridden at instantiation.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

    // Number of bits needed to index a queue of the given depth. The queue
    // depth is always a power of two, so pointers wrap naturally.
    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buffer_instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fifo
// Description : Synchronous FIFO with flush holding {instruction, PC+4}
//               entries for the fetch buffer. Head data is presented
//               combinationally; push/pop/flush act on the rising edge.
//
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               i_push   - write i_data at the tail
//               i_data   - entry to write
//               i_pop    - advance the head
//               i_flush  - discard every entry (wins over push and pop)
//               o_data   - head entry (undefined while empty)
//               o_count  - number of valid entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = calc_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [PTR_W:0]   o_count
);

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   c_cnt_max = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cnt_max);
    // Protect the queue against a misbehaving producer/consumer: popping an
    // empty queue is ignored, and pushing a full queue only succeeds when a
    // pop frees the head slot in the same cycle.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : instr_fifo
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Instruction fetch front end with a decoupling queue.
//               Generates sequential and redirected PCs, issues reads to a
//               one-cycle-latency synchronous instruction memory, and queues
//               {instruction, PC+4} for decode. A branch/jump redirect
//               flushes the queue and drops any read in flight.
//               FIFO_DEPTH must be a power of two and at least 2.
//
// Ports       : clock        - rising-edge clock
//               reset        - asynchronous active-low reset
//               br_taken     - branch redirect request
//               br_target    - branch target
//               j_taken      - jump request (none / immediate / register)
//               j_target     - immediate jump target
//               reg_A        - register jump target
//               imem_en      - memory read strobe
//               imem_addr    - word-aligned memory read address
//               imem_rdata   - read data, valid the cycle after imem_en
//               out_valid    - queue head valid towards decode
//               out_ready    - decode accepts the head
//               out_instr    - head instruction
//               out_pc_plus4 - head PC+4
//               occupancy    - current queue entry count
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = ADDRESS_WIDTH'(DEFAULT_BASE_ADDR),
    parameter int FIFO_DEPTH    = 4,
    localparam int PTR_W = calc_ptr_w(FIFO_DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     br_taken,
    input  logic [ADDRESS_WIDTH-1:0] br_target,
    input  logic [1:0]               j_taken,
    input  logic [ADDRESS_WIDTH-1:0] j_target,
    input  logic [ADDRESS_WIDTH-1:0] reg_A,
    output logic                     imem_en,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc_plus4,
    output logic [PTR_W:0]           occupancy
);

    localparam int ENTRY_W = DATA_WIDTH + ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH-1:0] c_pc_step    = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] c_align_mask = ~(ADDRESS_WIDTH'(3));
    localparam logic [PTR_W+1:0]         c_depth      = (PTR_W+2)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] r_fetch_pc;  // next PC to request
    logic                     r_inflight;  // a read was issued last cycle
    logic [ADDRESS_WIDTH-1:0] r_ret_pc;    // address of the read in flight

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    jump_kind_e               w_jump;
    logic                     w_redirect;
    logic [ADDRESS_WIDTH-1:0] w_target_raw;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic [PTR_W:0]           w_count;
    logic [PTR_W+1:0]         w_committed;
    logic                     w_credit;
    logic                     w_issue;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_head_valid;
    logic [ENTRY_W-1:0]       w_push_data;
    logic [ENTRY_W-1:0]       w_head;

    assign w_jump = jump_kind_e'(j_taken);

    // Redirect source priority: branch, then immediate jump, then register
    // jump. The reserved jump encoding behaves as "no request".
    always_comb begin
        w_redirect   = 1'b0;
        w_target_raw = br_target;
        if (br_taken) begin
            w_redirect   = 1'b1;
            w_target_raw = br_target;
        end else begin
            case (w_jump)
                J_IMM: begin
                    w_redirect   = 1'b1;
                    w_target_raw = j_target;
                end
                J_REG: begin
                    w_redirect   = 1'b1;
                    w_target_raw = reg_A;
                end
                default: begin
                    w_redirect   = 1'b0;
                    w_target_raw = br_target;
                end
            endcase
        end
    end

    assign w_target = w_target_raw & c_align_mask;

    // Credit: every outstanding read must find a free slot when it returns,
    // so queued entries plus the read in flight must stay below the depth.
    // A pop in this cycle is deliberately not counted as freeing a slot;
    // that keeps the issue decision independent of out_ready.
    assign w_committed = {1'b0, w_count} + {{(PTR_W+1){1'b0}}, r_inflight};
    assign w_credit    = (w_committed < c_depth);

    // The reset term keeps the strobe low for the whole time reset is held,
    // not just until the next edge.
    assign w_issue = reset && !w_redirect && w_credit;

    // A response arriving in the redirect cycle belongs to the old path.
    assign w_push       = r_inflight && !w_redirect;
    assign w_head_valid = (w_count != '0) && !w_redirect;
    assign w_pop        = w_head_valid && out_ready;

    assign w_push_data = {imem_rdata, r_ret_pc + c_pc_step};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= BASE_ADDRESS;
            r_inflight <= 1'b0;
            r_ret_pc   <= BASE_ADDRESS & c_align_mask;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + c_pc_step;
            r_inflight <= 1'b1;
            r_ret_pc   <= r_fetch_pc & c_align_mask;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_en      = w_issue;
    assign imem_addr    = r_fetch_pc & c_align_mask;
    assign out_valid    = w_head_valid;
    assign out_instr    = w_head[ENTRY_W-1 -: DATA_WIDTH];
    assign out_pc_plus4 = w_head[ADDRESS_WIDTH-1:0];
    assign occupancy    = w_count;

endmodule : fetch_buffer
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer. A scoreboard queue of
//               expected PCs is loaded whenever the fetch path is (re)started
//               and compared against every accepted head entry. Redirect
//               cases run from a vector table; startup, stall, in-flight
//               squash and asynchronous reset are hand-written sequences.
//               Depth-2 and depth-8 instances stream alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] BASE = 32'h8002_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main DUT (depth 4)
    logic          reset;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [1:0]    j_taken;
    logic [AW-1:0] j_target;
    logic [AW-1:0] reg_A;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc_plus4;
    logic [2:0]    occupancy;

    // Depth-2 and depth-8 instances, free-running with out_ready=1
    logic          reset2;
    logic          en2, en8, v2, v8;
    logic [AW-1:0] addr2, addr8, pc2, pc8;
    logic [DW-1:0] rd2, rd8, ins2, ins8;
    logic [1:0]    occ2;
    logic [3:0]    occ8;

    fetch_buffer dut (
        .clock(clock), .reset(reset),
        .br_taken(br_taken), .br_target(br_target),
        .j_taken(j_taken), .j_target(j_target), .reg_A(reg_A),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
        .occupancy(occupancy)
    );

    fetch_buffer #(.FIFO_DEPTH(2)) dut2 (
        .clock(clock), .reset(reset2),
        .br_taken(1'b0), .br_target(32'h0),
        .j_taken(2'd0), .j_target(32'h0), .reg_A(32'h0),
        .imem_en(en2), .imem_addr(addr2), .imem_rdata(rd2),
        .out_valid(v2), .out_ready(1'b1),
        .out_instr(ins2), .out_pc_plus4(pc2),
        .occupancy(occ2)
    );

    fetch_buffer #(.FIFO_DEPTH(8)) dut8 (
        .clock(clock), .reset(reset2),
        .br_taken(1'b0), .br_target(32'h0),
        .j_taken(2'd0), .j_target(32'h0), .reg_A(32'h0),
        .imem_en(en8), .imem_addr(addr8), .imem_rdata(rd8),
        .out_valid(v8), .out_ready(1'b1),
        .out_instr(ins8), .out_pc_plus4(pc8),
        .occupancy(occ8)
    );

    // Synchronous instruction memories: data word equals its address.
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= imem_addr;
        if (en2)     rd2        <= addr2;
        if (en8)     rd8        <= addr8;
    end

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: expected PCs in program order for the main DUT
    // ------------------------------------------------------------------
    logic [31:0] sb_q[$];

    task automatic sb_reload(input logic [31:0] start_pc);
        sb_q.delete();
        for (int i = 0; i < 128; i++) sb_q.push_back(start_pc + 32'(4 * i));
    endtask

    logic [31:0] exp_main;
    logic [31:0] exp2 = BASE;
    logic [31:0] exp8 = BASE;
    int          pops2 = 0;
    int          pops8 = 0;
    int          max_occ2 = 0;
    int          max_occ8 = 0;

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_main = sb_q.pop_front();
                check("pc_plus4", 64'(out_pc_plus4), 64'(exp_main + 32'd4));
                check("instr", 64'(out_instr), 64'(exp_main));
            end
        end
        if (reset2) begin
            if (int'(occ2) > max_occ2) max_occ2 = int'(occ2);
            if (int'(occ8) > max_occ8) max_occ8 = int'(occ8);
            if (v2) begin
                check("d2_pc_plus4", 64'(pc2), 64'(exp2 + 32'd4));
                check("d2_instr", 64'(ins2), 64'(exp2));
                exp2  = exp2 + 32'd4;
                pops2 = pops2 + 1;
            end
            if (v8) begin
                check("d8_pc_plus4", 64'(pc8), 64'(exp8 + 32'd4));
                check("d8_instr", 64'(ins8), 64'(exp8));
                exp8  = exp8 + 32'd4;
                pops8 = pops8 + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Redirect vector table
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic        br;
        logic [31:0] br_tgt;
        logic [1:0]  jk;
        logic [31:0] j_tgt;
        logic [31:0] ra;
        logic        exp_redir;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[4];

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_redirect;
        br_taken  = 1'b0;
        br_target = '0;
        j_taken   = 2'd0;
        j_target  = '0;
        reg_A     = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int bubbles;
        int max_occ;
        int s2, s8;

        vecs[0] = '{"br_over_jimm", 1'b1, 32'h8002_0100, 2'd1, 32'h8002_0200, 32'h0,          1'b1, 32'h8002_0100};
        vecs[1] = '{"jreg_align",   1'b0, 32'h0,         2'd2, 32'h8002_0200, 32'h8002_0043, 1'b1, 32'h8002_0040};
        vecs[2] = '{"j_reserved",   1'b0, 32'h0,         2'd3, 32'h8002_0200, 32'h8002_0043, 1'b0, 32'h0};
        vecs[3] = '{"jimm_align",   1'b0, 32'h0,         2'd1, 32'h8002_0302, 32'h0,          1'b1, 32'h8002_0300};

        reset  = 1'b0;
        reset2 = 1'b0;
        clear_redirect();
        out_ready = 1'b0;

        // Reset state
        repeat (2) step();
        @(negedge clock);
        check("rst_imem_en",   64'(imem_en),   64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'(BASE));

        // Startup latency and streaming
        step();
        reset     = 1'b1;
        reset2    = 1'b1;
        out_ready = 1'b1;
        sb_reload(BASE);
        @(negedge clock);
        check("first_imem_en",   64'(imem_en),   64'd1);
        check("first_imem_addr", 64'(imem_addr), 64'(BASE));
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("first_out_latency", 64'(lat), 64'd2);
        bubbles = 0;
        repeat (8) begin
            @(negedge clock);
            if (!out_valid) bubbles++;
        end
        check("stream_bubbles", 64'(bubbles), 64'd0);

        // Decode stall: queue saturates, fetch stops, then drains in order
        step();
        out_ready = 1'b0;
        max_occ   = 0;
        repeat (10) begin
            @(negedge clock);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        check("stall_occ_max",   64'(max_occ),   64'd4);
        check("stall_occupancy", 64'(occupancy), 64'd4);
        check("stall_imem_en",   64'(imem_en),   64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        step();
        out_ready = 1'b1;
        @(negedge clock);
        check("resume_no_credit", 64'(imem_en), 64'd0);
        step();
        @(negedge clock);
        check("resume_fetch", 64'(imem_en), 64'd1);
        repeat (18) step();

        // Table-driven redirects against a full queue
        for (int v = 0; v < 4; v++) begin
            step();
            out_ready = 1'b0;
            repeat (7) step();
            @(negedge clock);
            check({vecs[v].name, "_prefill_occ"}, 64'(occupancy), 64'd4);
            step();
            br_taken  = vecs[v].br;
            br_target = vecs[v].br_tgt;
            j_taken   = vecs[v].jk;
            j_target  = vecs[v].j_tgt;
            reg_A     = vecs[v].ra;
            @(negedge clock);
            check({vecs[v].name, "_valid_R"}, 64'(out_valid), vecs[v].exp_redir ? 64'd0 : 64'd1);
            check({vecs[v].name, "_en_R"},    64'(imem_en),   64'd0);
            step();
            clear_redirect();
            if (vecs[v].exp_redir) sb_reload(vecs[v].exp_addr);
            @(negedge clock);
            check({vecs[v].name, "_occ_R1"}, 64'(occupancy), vecs[v].exp_redir ? 64'd0 : 64'd4);
            check({vecs[v].name, "_en_R1"},  64'(imem_en),   vecs[v].exp_redir ? 64'd1 : 64'd0);
            if (vecs[v].exp_redir)
                check({vecs[v].name, "_addr_R1"}, 64'(imem_addr), 64'(vecs[v].exp_addr));
            step();
            out_ready = 1'b1;
            repeat (12) step();
        end

        // Redirect while streaming: in-flight read is squashed
        br_taken  = 1'b1;
        br_target = 32'h8002_0100;
        j_taken   = 2'd1;
        j_target  = 32'h8002_0800;
        sb_reload(32'h8002_0100);
        @(negedge clock);
        check("sq_valid_R", 64'(out_valid), 64'd0);
        check("sq_occ_R",   64'(occupancy) != 64'd0 ? 64'd1 : 64'd0, 64'd1);
        step();
        clear_redirect();
        @(negedge clock);
        check("sq_occ_R1",  64'(occupancy), 64'd0);
        check("sq_en_R1",   64'(imem_en),   64'd1);
        check("sq_addr_R1", 64'(imem_addr), 64'h8002_0100);
        step();
        @(negedge clock);
        check("sq_valid_R2", 64'(out_valid), 64'd0);
        step();
        @(negedge clock);
        check("sq_valid_R3", 64'(out_valid),    64'd1);
        check("sq_pc_R3",    64'(out_pc_plus4), 64'h8002_0104);
        repeat (10) step();

        // Asynchronous reset between edges mid-stream
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_imem_en",   64'(imem_en),   64'd0);
        check("arst_occupancy", 64'(occupancy), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        sb_reload(BASE);
        @(negedge clock);
        check("arst_rel_addr", 64'(imem_addr), 64'(BASE));
        check("arst_rel_en",   64'(imem_en),   64'd1);
        repeat (12) step();

        // Depth-2 / depth-8 throughput windows
        s2 = pops2;
        s8 = pops8;
        repeat (60) @(posedge clock);
        check("d2_rate_at_least_half", (pops2 - s2 >= 30) ? 64'd1 : 64'd0, 64'd1);
        check("d2_rate_below_full",    (pops2 - s2 < 60)  ? 64'd1 : 64'd0, 64'd1);
        check("d8_full_rate",          64'(pops8 - s8), 64'd60);
        check("d2_occ_max",            (max_occ2 <= 2) ? 64'd1 : 64'd0, 64'd1);
        check("d8_occ_max",            (max_occ8 <= 8) ? 64'd1 : 64'd0, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_buffer
`default_nettype wire
